// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, synchronous-read data memory between
// the CPU load/store port (port 0, fixed priority) and an auxiliary master
// (port 1, e.g. program loader or DMA). Port 1 may hold the memory for a
// burst of up to MAX_BURST beats once it wins a beat with p1_last=0.
//
// Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//   When defined, a wait counter tracks how long port 1 has been held off in
//   CPU_PRI; on reaching MAX_WAIT, port 1 is granted as if in AUX_BURST.
//
// Handshake: a beat transfers in a cycle where pN_valid && pN_ready. Ready
// is combinational from state and valids; a requester must hold its request
// stable until ready. Read data returns exactly one cycle after acceptance,
// flagged by pN_rvalid on the issuing port only; both rdata buses carry the
// memory data in that cycle and are 0 otherwise.
//
// dbg_state_o / dbg_wait_o expose the FSM state and starvation counter.
// Burst accounting assumes MAX_BURST >= 2.
module dmem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int MAX_BURST = 16,
  parameter int MAX_WAIT  = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             p0_valid,
  input  logic [ADDR_W-1:0]                p0_addr,
  input  logic [31:0]                      p0_wdata,
  input  logic [3:0]                       p0_we,
  output logic                             p0_ready,
  output logic                             p0_rvalid,
  output logic [31:0]                      p0_rdata,
  input  logic                             p1_valid,
  input  logic [ADDR_W-1:0]                p1_addr,
  input  logic [31:0]                      p1_wdata,
  input  logic [3:0]                       p1_we,
  input  logic                             p1_last,
  output logic                             p1_ready,
  output logic                             p1_rvalid,
  output logic [31:0]                      p1_rdata,
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [31:0]                      mem_wdata,
  output logic [3:0]                       mem_we,
  input  logic [31:0]                      mem_rdata,
  output logic                             dbg_state_o,
  output logic [$clog2(MAX_WAIT+1)-1:0]    dbg_wait_o
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(MAX_BURST);

  typedef enum logic {
    CPU_PRI   = 1'b0,
    AUX_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              pend_q, pend_d;
  logic              tag_q, tag_d;
  logic              force_aux;
  logic              aux_grant;
  logic              acc0, acc1;
  logic              rsp_any;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Port 1 has waited long enough: grant it as in a burst for this cycle.
  always_comb force_aux = (state_q == CPU_PRI) && (wait_q == WAIT_LIM);

  // Count cycles port 1 is held off by port 0; any accepted p1 beat clears.
  always_comb begin
    wait_d = wait_q;
    if (acc1) begin
      wait_d = '0;
    end else if ((state_q == CPU_PRI) && p1_valid && !p1_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign dbg_wait_o = wait_q;
`else
  assign force_aux  = 1'b0;
  assign dbg_wait_o = '0;
`endif

  // Grant decision and memory request mux; nothing is granted during reset.
  always_comb begin
    aux_grant = (state_q == AUX_BURST) || force_aux;
    p0_ready  = !rst && p0_valid && !aux_grant;
    p1_ready  = !rst && p1_valid && (aux_grant || !p0_valid);
    acc0      = p0_ready;
    acc1      = p1_ready;
    mem_en    = acc0 || acc1;
    mem_addr  = acc1 ? p1_addr  : p0_addr;
    mem_wdata = acc1 ? p1_wdata : p0_wdata;
    if (acc1)      mem_we = p1_we;
    else if (acc0) mem_we = p0_we;
    else           mem_we = 4'h0;
  end

  // Next-state logic: burst entry/exit, beat counting and read tagging.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pend_d  = (acc0 && (p0_we == 4'h0)) || (acc1 && (p1_we == 4'h0));
    tag_d   = acc1;
    case (state_q)
      CPU_PRI: begin
        if (acc1 && !p1_last) begin
          state_d = AUX_BURST;
          beat_d  = BEAT_W'(1);
        end
      end
      AUX_BURST: begin
        if (acc1) begin
          if (p1_last || ((beat_q + BEAT_W'(1)) == BURST_LIM)) begin
            state_d = CPU_PRI;
            beat_d  = '0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = CPU_PRI;
        beat_d  = '0;
      end
    endcase
  end

  // FSM register: state, beat counter and the one-deep read tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU_PRI;
      beat_q  <= '0;
      pend_q  <= 1'b0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      tag_q   <= tag_d;
    end
  end

  // Response routing; a response pending across reset is suppressed.
  always_comb begin
    p0_rvalid = !rst && pend_q && !tag_q;
    p1_rvalid = !rst && pend_q && tag_q;
    rsp_any   = p0_rvalid || p1_rvalid;
    p0_rdata  = rsp_any ? mem_rdata : 32'h0;
    p1_rdata  = rsp_any ? mem_rdata : 32'h0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// synchronous-read memory and a read-response scoreboard. Inputs change
// 1 time unit after posedge; outputs are sampled on negedge.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_valid, p0_ready, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata, p0_rdata;
  logic [3:0]        p0_we;
  logic              p1_valid, p1_ready, p1_rvalid, p1_last;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata, p1_rdata;
  logic [3:0]        p1_we;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_we;
  logic              dbg_state;
  logic [6:0]        dbg_wait;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // scoreboard entry: {due_cycle[15:0], port, data[31:0]}
  logic [48:0] exp_q[$];
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        p1_pending;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(16), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
    .p1_last(p1_last), .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dbg_state_o(dbg_state), .dbg_wait_o(dbg_wait)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural single-port memory, read data valid the cycle after strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) mem_rdata <= mem[mem_addr];
      else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_check();
    @(negedge clk);
  endtask

  task automatic idle_all();
    p0_valid = 1'b0; p0_we = 4'h0;
    p1_valid = 1'b0; p1_we = 4'h0; p1_last = 1'b0;
  endtask

  task automatic drv0(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] we);
    p0_valid = 1'b1; p0_addr = a; p0_wdata = d; p0_we = we;
  endtask

  task automatic drv1(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] we,
                      input logic last);
    p1_valid = 1'b1; p1_addr = a; p1_wdata = d; p1_we = we; p1_last = last;
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] we);
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic exp_read(input logic port, input logic [31:0] data);
    int due;
    due = cyc + 1;
    exp_q.push_back({due[15:0], port, data});
  endtask

  // scoreboard: responses due this cycle must appear, nothing else may
  always @(negedge clk) begin : mon
    logic [48:0] e;
    if ((exp_q.size() > 0) && (exp_q[0][48:33] == cyc[15:0])) begin
      e = exp_q.pop_front();
      chk1("rsp_p0_rvalid", p0_rvalid, ~e[32]);
      chk1("rsp_p1_rvalid", p1_rvalid, e[32]);
      chk("rsp_p0_rdata", p0_rdata, e[31:0]);
      chk("rsp_p1_rdata", p1_rdata, e[31:0]);
    end else begin
      chk1("idle_p0_rvalid", p0_rvalid, 1'b0);
      chk1("idle_p1_rvalid", p1_rvalid, 1'b0);
      chk("idle_p0_rdata", p0_rdata, 32'h0);
      chk("idle_p1_rdata", p1_rdata, 32'h0);
    end
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = {i[15:0], ~i[15:0]};
      ref_mem[i] = {i[15:0], ~i[15:0]};
    end
    mem[16]     = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    p1_pending = 1'b0;
    idle_all();

    // reset: valids high, everything held off
    rst = 1'b1;
    p0_valid = 1'b1; p1_valid = 1'b1;
    next_cycle();
    at_check();
    chk1("rst_p0_ready", p0_ready, 1'b0);
    chk1("rst_p1_ready", p1_ready, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_state", dbg_state, 1'b0);
    next_cycle();
    rst = 1'b0;
    idle_all();
    at_check();
    chk1("idle_p0_ready", p0_ready, 1'b0);
    chk1("idle_p1_ready", p1_ready, 1'b0);
    chk1("idle_mem_en", mem_en, 1'b0);
    chk("idle_mem_we", 32'(mem_we), 32'h0);

    // port 0 read of 0x10
    next_cycle();
    drv0(14'h0010, 32'h0, 4'h0);
    exp_read(1'b0, 32'hDEADBEEF);
    at_check();
    chk1("t1_p0_ready", p0_ready, 1'b1);
    chk1("t1_p1_ready", p1_ready, 1'b0);
    chk1("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h10);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    next_cycle();
    idle_all();
    at_check();

    // contention: port 0 write wins, port 1 read follows
    next_cycle();
    drv0(14'h0020, 32'h12345678, 4'hF);
    drv1(14'h0020, 32'h0, 4'h0, 1'b1);
    model_write(14'h0020, 32'h12345678, 4'hF);
    at_check();
    chk1("t2_p0_ready", p0_ready, 1'b1);
    chk1("t2_p1_ready", p1_ready, 1'b0);
    chk("t2_mem_we", 32'(mem_we), 32'hF);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_mem_addr", 32'(mem_addr), 32'h20);
    next_cycle();
    p0_valid = 1'b0;
    exp_read(1'b1, ref_mem[14'h0020]);
    at_check();
    chk1("t2b_p1_ready", p1_ready, 1'b1);
    chk1("t2b_p0_ready", p0_ready, 1'b0);
    chk("t2b_mem_we", 32'(mem_we), 32'h0);
    next_cycle();
    idle_all();
    at_check();
    chk1("t2_single_last_state", dbg_state, 1'b0);

    // 4-beat port 1 write burst with port 0 waiting
    next_cycle();
    drv1(14'h0100, 32'hA0000001, 4'hF, 1'b0);
    model_write(14'h0100, 32'hA0000001, 4'hF);
    at_check();
    chk1("t3_b1_p1_ready", p1_ready, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      next_cycle();
      drv0(14'h0100, 32'h0, 4'h0);
      drv1(14'(32'h100 + i - 1), 32'hA0000000 + i, 4'hF, (i == 4));
      model_write(14'(32'h100 + i - 1), 32'hA0000000 + i, 4'hF);
      at_check();
      chk1("t3_p0_stall", p0_ready, 1'b0);
      chk1("t3_p1_ready", p1_ready, 1'b1);
      chk1("t3_state_aux", dbg_state, 1'b1);
      chk("t3_mem_addr", 32'(mem_addr), 32'h100 + i - 1);
    end
    next_cycle();
    p1_valid = 1'b0; p1_last = 1'b0;
    exp_read(1'b0, ref_mem[14'h0100]);
    at_check();
    chk1("t3_release_state", dbg_state, 1'b0);
    chk1("t3_release_p0_ready", p0_ready, 1'b1);

    // alternating back-to-back reads
    next_cycle();
    drv0(14'h0101, 32'h0, 4'h0);
    exp_read(1'b0, ref_mem[14'h0101]);
    at_check();
    chk1("alt_a_p0_ready", p0_ready, 1'b1);
    next_cycle();
    p0_valid = 1'b0;
    drv1(14'h0102, 32'h0, 4'h0, 1'b1);
    exp_read(1'b1, ref_mem[14'h0102]);
    at_check();
    chk1("alt_b_p1_ready", p1_ready, 1'b1);
    next_cycle();
    p1_valid = 1'b0;
    drv0(14'h0103, 32'h0, 4'h0);
    exp_read(1'b0, ref_mem[14'h0103]);
    at_check();
    chk1("alt_c_p0_ready", p0_ready, 1'b1);
    next_cycle();
    idle_all();
    at_check();

    // 20-beat burst with p1_last low: released after beat 16
    next_cycle();
    drv1(14'h0300, 32'hB0000000, 4'hF, 1'b0);
    model_write(14'h0300, 32'hB0000000, 4'hF);
    at_check();
    chk1("t4_b1_p1_ready", p1_ready, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      next_cycle();
      drv0(14'h0200, 32'hC0C0C0C0, 4'hF);
      drv1(14'(32'h300 + i - 1), 32'hB0000000 + i, 4'hF, 1'b0);
      model_write(14'(32'h300 + i - 1), 32'hB0000000 + i, 4'hF);
      at_check();
      chk1("t4_p1_ready", p1_ready, 1'b1);
      chk1("t4_p0_stall", p0_ready, 1'b0);
    end
    next_cycle();
    drv1(14'h0310, 32'hB0000011, 4'hF, 1'b0);
    model_write(14'h0200, 32'hC0C0C0C0, 4'hF);
    at_check();
    chk1("t4_cap_state", dbg_state, 1'b0);
    chk1("t4_cap_p0_ready", p0_ready, 1'b1);
    chk1("t4_cap_p1_ready", p1_ready, 1'b0);
    for (int i = 17; i <= 20; i++) begin
      next_cycle();
      p0_valid = 1'b0;
      drv1(14'(32'h300 + i - 1), 32'hB0000000 + i, 4'hF, 1'b0);
      model_write(14'(32'h300 + i - 1), 32'hB0000000 + i, 4'hF);
      at_check();
      chk1("t4_tail_p1_ready", p1_ready, 1'b1);
    end
    // burst still open with port 1 idle: memory idle, port 0 held off
    next_cycle();
    p1_valid = 1'b0;
    drv0(14'h0200, 32'hC0C0C0C0, 4'hF);
    at_check();
    chk1("t4_hold_state", dbg_state, 1'b1);
    chk1("t4_hold_p0_ready", p0_ready, 1'b0);
    chk1("t4_hold_mem_en", mem_en, 1'b0);

    // reset right after an accepted port 1 read in AUX_BURST
    next_cycle();
    p0_valid = 1'b0;
    drv1(14'h0300, 32'h0, 4'h0, 1'b0);
    at_check();
    chk1("t5_p1_ready", p1_ready, 1'b1);
    next_cycle();
    rst = 1'b1;
    idle_all();
    at_check();
    chk1("t5_rst_p1_rvalid", p1_rvalid, 1'b0);
    chk1("t5_rst_p0_rvalid", p0_rvalid, 1'b0);
    next_cycle();
    rst = 1'b0;
    drv0(14'h0200, 32'hC0C0C0C0, 4'hF);
    model_write(14'h0200, 32'hC0C0C0C0, 4'hF);
    at_check();
    chk1("t5_post_state", dbg_state, 1'b0);
    chk1("t5_post_p0_ready", p0_ready, 1'b1);
    chk1("t5_post_p1_rvalid", p1_rvalid, 1'b0);

    // starvation: port 0 always valid, port 1 single beat waiting
    next_cycle();
    idle_all();
    p1_pending = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      logic ex;
      next_cycle();
      ex = GUARD && (k == 65);
      drv0(14'h0400, 32'h0D0D0D0D, 4'hF);
      if (!ex) model_write(14'h0400, 32'h0D0D0D0D, 4'hF);
      if (p1_pending) drv1(14'h0401, 32'hE0E0E0E0, 4'hF, 1'b1);
      else            p1_valid = 1'b0;
      if (ex) model_write(14'h0401, 32'hE0E0E0E0, 4'hF);
      at_check();
      chk1("t6_p1_ready", p1_ready, ex);
      chk1("t6_p0_ready", p0_ready, ~ex);
      if (ex) p1_pending = 1'b0;
    end
    next_cycle();
    idle_all();
    at_check();
    chk1("t6_state", dbg_state, 1'b0);

    // read back memory contents written through both ports
    next_cycle();
    drv0(14'h0401, 32'h0, 4'h0);
    exp_read(1'b0, ref_mem[14'h0401]);
    at_check();
    next_cycle();
    drv0(14'h030F, 32'h0, 4'h0);
    exp_read(1'b0, ref_mem[14'h030F]);
    at_check();
    next_cycle();
    p0_valid = 1'b0;
    drv1(14'h0313, 32'h0, 4'h0, 1'b1);
    exp_read(1'b1, ref_mem[14'h0313]);
    at_check();
    next_cycle();
    idle_all();
    at_check();
    next_cycle();
    at_check();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
